// File: rtl/uart_tx_sched_pkg.sv
// Shared types, default parameters and width helper for the uart_tx scheduler.
package uart_tx_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_BYTE_CYCLES = 4340;
    localparam int unsigned DEFAULT_DEPTH       = 4;

    // Bits needed to index `value` entries; never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester push ports and uart_tx-facing outputs of the scheduler.
interface uart_tx_sched_if;

    logic       req0_en;
    logic [7:0] req0_data;
    logic       req1_en;
    logic [7:0] req1_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] ovf;
    logic       idle;

    modport master (
        output req0_en, req0_data, req1_en, req1_data,
        input  tx_data, tx_start, ovf, idle
    );

    modport slave (
        input  req0_en, req0_data, req1_en, req1_data,
        output tx_data, tx_start, ovf, idle
    );

endinterface

// File: rtl/uart_tx_sched_fifo.sv
// DEPTH x 8 synchronous FIFO for one requester; a push while full is dropped and flagged.
module sched_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  logic [7:0]                      push_data,
    input  logic                            pop,
    output logic [7:0]                      pop_data,
    output logic [clog2_min1(DEPTH):0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            ovf_pulse
);

    localparam int unsigned AW   = clog2_min1(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign full      = (r_count == CNTW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign ovf_pulse = push && full;

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, byte-time-paced scheduler of two requester FIFOs onto uart_tx.
// Define TX_SCHED_STATS_EN to add per-requester issued-byte counters (tx_count).
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned BYTE_CYCLES = DEFAULT_BYTE_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    uart_tx_sched_if.slave     bus
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [1:0][15:0]   tx_count
`endif
);

    localparam int unsigned AW = clog2_min1(DEPTH);
    localparam int unsigned CW = clog2_min1(BYTE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(BYTE_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_counter;
    logic          r_last;
    logic [7:0]    r_tx_data;
    logic          r_tx_start;
    logic          r_idle;
    logic [1:0]    r_ovf;

    logic [1:0]    w_empty;
    logic [1:0]    w_full;
    logic [1:0]    w_ovf_pulse;
    logic [1:0]    w_pop;
    logic [7:0]    w_data0;
    logic [7:0]    w_data1;
    logic [AW:0]   w_count0;
    logic [AW:0]   w_count1;
    logic          w_any;
    logic          w_grant;
    logic          w_idle_nxt;

    sched_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.req0_en),
        .push_data (bus.req0_data),
        .pop       (w_pop[0]),
        .pop_data  (w_data0),
        .count     (w_count0),
        .full      (w_full[0]),
        .empty     (w_empty[0]),
        .ovf_pulse (w_ovf_pulse[0])
    );

    sched_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.req1_en),
        .push_data (bus.req1_data),
        .pop       (w_pop[1]),
        .pop_data  (w_data1),
        .count     (w_count1),
        .full      (w_full[1]),
        .empty     (w_empty[1]),
        .ovf_pulse (w_ovf_pulse[1])
    );

    assign w_any   = !w_empty[0] || !w_empty[1];
    assign w_grant = (!w_empty[0] && !w_empty[1]) ? ~r_last : w_empty[0];
    assign w_pop   = (r_state == IDLE && w_any) ? {w_grant, ~w_grant} : 2'b00;

    // idle is registered but must reflect the cycle it appears in, so it is
    // computed from next state and next occupancy (no pop can occur when both are empty).
    assign w_idle_nxt = (r_state == IDLE || r_counter == '0)
                     && w_count0 == '0 && w_count1 == '0
                     && !(bus.req0_en && !w_full[0])
                     && !(bus.req1_en && !w_full[1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT;
            r_counter  <= CNT_MAX;
            r_last     <= 1'b1;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_idle     <= 1'b0;
            r_ovf      <= '0;
        end else begin
            r_ovf      <= r_ovf | w_ovf_pulse;
            r_tx_start <= 1'b0;
            r_idle     <= w_idle_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_tx_data  <= w_grant ? w_data1 : w_data0;
                        r_tx_start <= 1'b1;
                        r_last     <= w_grant;
                        r_counter  <= CNT_MAX;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_counter == '0) r_state <= IDLE;
                    else                 r_counter <= r_counter - 1'b1;
                end
                default: r_state <= WAIT;
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    logic [1:0][15:0] r_tx_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_count <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_tx_count[w_grant] <= r_tx_count[w_grant] + 16'd1;
        end
    end

    assign tx_count = r_tx_count;
`endif

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = r_tx_start;
    assign bus.ovf      = r_ovf;
    assign bus.idle     = r_idle;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: queue-level reference model, negedge monitor.
module tb_uart_tx_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BC    = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_tx_sched_if bus();

`ifdef TX_SCHED_STATS_EN
    logic [1:0][15:0] tx_count;
`endif

    uart_tx_sched #(.DEPTH(DEPTH), .BYTE_CYCLES(BC)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus)
`ifdef TX_SCHED_STATS_EN
        ,
        .tx_count (tx_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int         at;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         edge_n     = 0;
    int         ready_edge = BC + 1;
    bit         last_g     = 1'b1;
    logic [1:0] m_ovf      = 2'b00;
    bit         m_idle     = 1'b0;
    int         m_cnt[2]   = '{0, 0};
    int         n_checks   = 0;
    int         n_pass     = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    endfunction

    // Reference model: a byte may leave only once BC+1 edges have passed since the
    // previous issue (or since reset); pushes land after that edge's pop decision.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            exp_q.delete();
            edge_n     = 0;
            ready_edge = BC + 1;
            last_g     = 1'b1;
            m_ovf      = 2'b00;
            m_idle     = 1'b0;
            m_cnt      = '{0, 0};
        end else begin
            bit         full0, full1, g;
            logic [7:0] d;
            edge_n++;
            full0 = (q0.size() == DEPTH);
            full1 = (q1.size() == DEPTH);
            if (edge_n >= ready_edge && (q0.size() > 0 || q1.size() > 0)) begin
                if (q0.size() > 0 && q1.size() > 0) g = !last_g;
                else                                g = (q0.size() == 0);
                d = g ? q1.pop_front() : q0.pop_front();
                last_g = g;
                m_cnt[g]++;
                exp_q.push_back('{at: edge_n, data: d});
                ready_edge = edge_n + BC + 1;
            end
            if (bus.req0_en) begin
                if (full0) m_ovf[0] = 1'b1;
                else       q0.push_back(bus.req0_data);
            end
            if (bus.req1_en) begin
                if (full1) m_ovf[1] = 1'b1;
                else       q1.push_back(bus.req1_data);
            end
            m_idle = (edge_n + 1 >= ready_edge) && q0.size() == 0 && q1.size() == 0;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
            chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
            chk("rst_ovf",      32'(bus.ovf),      32'd0);
            chk("rst_idle",     32'(bus.idle),     32'd0);
        end else begin
            chk("idle", 32'(bus.idle), 32'(m_idle));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("tx_start_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_start_edge", 32'(edge_n), 32'(e.at));
                    chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= edge_n) begin
                e = exp_q.pop_front();
                chk("tx_start_missing", 32'd0, 32'd1);
            end
        end
    end

    task automatic step(input bit e0, input logic [7:0] d0, input bit e1, input logic [7:0] d1);
        bus.req0_en   = e0;
        bus.req0_data = d0;
        bus.req1_en   = e1;
        bus.req1_data = d1;
        @(posedge clock);
        #1;
        bus.req0_en = 1'b0;
        bus.req1_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int unsigned odds;
        bus.req0_en   = 1'b0;
        bus.req0_data = '0;
        bus.req1_en   = 1'b0;
        bus.req1_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // first push straight after reset waits out the reset byte-time
        step(1'b1, 8'h41, 1'b0, 8'h00);
        wait_cycles(3 * BC);

        // back-to-back pushes while idle
        step(1'b1, 8'h10, 1'b0, 8'h00);
        step(1'b1, 8'h11, 1'b0, 8'h00);
        step(1'b1, 8'h12, 1'b0, 8'h00);
        wait_cycles(4 * (BC + 1));

        // simultaneous fills: A0,B0,A1,B1
        do_reset(2);
        step(1'b1, 8'hA0, 1'b1, 8'hB0);
        step(1'b1, 8'hA1, 1'b1, 8'hB1);
        wait_cycles(5 * (BC + 1));

        // overflow on requester 1 while held in WAIT
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 8'(8'hC0 + i));
        wait_cycles(6 * (BC + 1));

        // reset mid-WAIT with bytes queued, then a fresh push
        step(1'b1, 8'h31, 1'b0, 8'h00);
        step(1'b1, 8'h32, 1'b0, 8'h00);
        step(1'b1, 8'h33, 1'b0, 8'h00);
        wait_cycles(3);
        do_reset(2);
        step(1'b1, 8'h5A, 1'b0, 8'h00);
        wait_cycles(2 * (BC + 1));

        // randomized traffic with varying intensity
        do_reset(1);
        for (int blk = 0; blk < 8; blk++) begin
            odds = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 32);
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, odds - 1) == 0, 8'($urandom),
                     $urandom_range(0, odds - 1) == 0, 8'($urandom));
            end
        end

        // bounded drain
        for (int c = 0; c < (2 * DEPTH + 2) * (BC + 1) && exp_q.size() > 0; c++) wait_cycles(1);
        wait_cycles(2);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
`ifdef TX_SCHED_STATS_EN
        chk("tx_count0", 32'(tx_count[0]), 32'(m_cnt[0] % 65536));
        chk("tx_count1", 32'(tx_count[1]), 32'(m_cnt[1] % 65536));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
